// File: rtl/entropy_conditioner.sv
// Von Neumann debiaser for a raw entropy bit stream with a repetition-count health test,
// a 4-entry output FIFO and framing of the debiased stream into fixed-length test sequences.
module entropy_conditioner #(
    parameter int SEQ_LEN    = 128,
    parameter int REP_CUTOFF = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic raw_bit,
    input  logic raw_vld,
    output logic epsilon_dat,
    output logic epsilon_vld,
    input  logic epsilon_rdy,
    output logic seq_first,
    output logic seq_last,
    output logic rep_fail,
    output logic ovf
);

    typedef enum logic [1:0] {FIRST, SECOND, FAIL} state_t;

    localparam logic [7:0]  CUTOFF  = 8'(REP_CUTOFF);
    localparam logic [15:0] SEQ_MAX = 16'(SEQ_LEN - 1);

    state_t      state_reg;
    logic        held_reg;
    logic [7:0]  rep_cnt_reg;
    logic [7:0]  rep_cnt_next;
    logic        last_raw_reg;
    logic        mem_reg [4];
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  count_reg;
    logic [15:0] seq_cnt_reg;
    logic        rep_fail_reg;
    logic        ovf_reg;

    logic sample;
    logic rep_trip;
    logic push;
    logic pop;
    logic full;
    logic accept;
    logic drop;

    // Once in FAIL the source is no longer trusted, so nothing it sends is looked at.
    always_comb begin
        sample       = raw_vld && (state_reg != FAIL);
        rep_cnt_next = rep_cnt_reg;
        if (sample) begin
            if (rep_cnt_reg == 8'd0 || raw_bit != last_raw_reg) begin
                rep_cnt_next = 8'd1;
            end else if (rep_cnt_reg != CUTOFF) begin
                rep_cnt_next = rep_cnt_reg + 8'd1;
            end
        end
        rep_trip = sample && (rep_cnt_next == CUTOFF);
        push     = sample && en && (state_reg == SECOND) && (raw_bit != held_reg) && !rep_trip;
        pop      = epsilon_vld && epsilon_rdy;
        full     = (count_reg == 3'd4);
        accept   = push && (!full || pop);
        drop     = push && full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= FIRST;
            held_reg     <= 1'b0;
            rep_cnt_reg  <= 8'd0;
            last_raw_reg <= 1'b0;
            for (int i = 0; i < 4; i++) mem_reg[i] <= 1'b0;
            wr_ptr_reg   <= 2'd0;
            rd_ptr_reg   <= 2'd0;
            count_reg    <= 3'd0;
            seq_cnt_reg  <= 16'd0;
            rep_fail_reg <= 1'b0;
            ovf_reg      <= 1'b0;
        end else begin
            rep_cnt_reg <= rep_cnt_next;
            if (sample) last_raw_reg <= raw_bit;

            if (rep_trip) begin
                // Alarm wins over any push/pop this cycle: flush and park until reset.
                state_reg    <= FAIL;
                rep_fail_reg <= 1'b1;
                wr_ptr_reg   <= 2'd0;
                rd_ptr_reg   <= 2'd0;
                count_reg    <= 3'd0;
                seq_cnt_reg  <= 16'd0;
            end else begin
                unique case (state_reg)
                    FIRST: begin
                        if (sample && en) begin
                            held_reg  <= raw_bit;
                            state_reg <= SECOND;
                        end
                    end
                    SECOND: begin
                        if (!en || sample) state_reg <= FIRST;
                    end
                    default: state_reg <= FAIL;
                endcase

                if (accept) begin
                    mem_reg[wr_ptr_reg] <= held_reg;
                    wr_ptr_reg          <= wr_ptr_reg + 2'd1;
                end
                if (pop) begin
                    rd_ptr_reg  <= rd_ptr_reg + 2'd1;
                    seq_cnt_reg <= (seq_cnt_reg == SEQ_MAX) ? 16'd0 : seq_cnt_reg + 16'd1;
                end
                count_reg <= count_reg + 3'(accept) - 3'(pop);
                if (drop) ovf_reg <= 1'b1;
            end
        end
    end

    assign epsilon_dat = mem_reg[rd_ptr_reg];
    assign epsilon_vld = (count_reg != 3'd0);
    assign seq_first   = epsilon_vld && (seq_cnt_reg == 16'd0);
    assign seq_last    = epsilon_vld && (seq_cnt_reg == SEQ_MAX);
    assign rep_fail    = rep_fail_reg;
    assign ovf         = ovf_reg;

endmodule

// File: tb/tb_entropy_conditioner.sv
// Directed bench for entropy_conditioner with SEQ_LEN=4 and REP_CUTOFF=8.
module tb_entropy_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic raw_bit = 1'b0;
    logic raw_vld = 1'b0;
    logic epsilon_rdy = 1'b0;
    logic epsilon_dat, epsilon_vld, seq_first, seq_last, rep_fail, ovf;

    int errors = 0;
    int checks = 0;

    entropy_conditioner #(.SEQ_LEN(4), .REP_CUTOFF(8)) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .raw_bit(raw_bit),
        .raw_vld(raw_vld),
        .epsilon_dat(epsilon_dat),
        .epsilon_vld(epsilon_vld),
        .epsilon_rdy(epsilon_rdy),
        .seq_first(seq_first),
        .seq_last(seq_last),
        .rep_fail(rep_fail),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One raw sample per call; outputs are looked at 1ns after the sampling edge.
    task automatic drive_raw(input logic b);
        raw_bit = b;
        raw_vld = 1'b1;
        @(posedge clk);
        #1;
        raw_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        raw_vld = 1'b0;
        en = 1'b1;
        idle(2);
        check("rst_vld", epsilon_vld, 0);
        check("rst_dat", epsilon_dat, 0);
        check("rst_first", seq_first, 0);
        check("rst_last", seq_last, 0);
        check("rst_rep_fail", rep_fail, 0);
        check("rst_ovf", ovf, 0);
        rst = 1'b0;
        idle(1);
        check("post_rst_vld", epsilon_vld, 0);
    endtask

    logic exp_bits [4];

    initial begin
        // Basic debiasing: 01 -> 0, 10 -> 1, 00 and 11 discarded
        do_reset();
        epsilon_rdy = 1'b1;
        drive_raw(0); check("t1_vld_a", epsilon_vld, 0);
        drive_raw(1); check("t1_vld_b", epsilon_vld, 1);
        check("t1_dat_b", epsilon_dat, 0);
        check("t1_first_b", seq_first, 1);
        drive_raw(1); check("t1_vld_c", epsilon_vld, 0);
        drive_raw(0); check("t1_vld_d", epsilon_vld, 1);
        check("t1_dat_d", epsilon_dat, 1);
        check("t1_first_d", seq_first, 0);
        drive_raw(0); check("t1_vld_e", epsilon_vld, 0);
        drive_raw(0); check("t1_vld_f", epsilon_vld, 0);
        drive_raw(1); check("t1_vld_g", epsilon_vld, 0);
        drive_raw(1); check("t1_vld_h", epsilon_vld, 0);
        idle(2);      check("t1_vld_end", epsilon_vld, 0);

        // Overflow: 5 pairs with rdy low, fifth bit dropped
        do_reset();
        epsilon_rdy = 1'b0;
        exp_bits[0] = 0; exp_bits[1] = 1; exp_bits[2] = 0; exp_bits[3] = 1;
        drive_raw(0); drive_raw(1);
        drive_raw(1); drive_raw(0);
        drive_raw(0); drive_raw(1);
        drive_raw(1); drive_raw(0);
        check("t2_ovf_4", ovf, 0);
        drive_raw(0); drive_raw(1);
        check("t2_ovf_5", ovf, 1);
        check("t2_hold_dat", epsilon_dat, 0);
        idle(1);
        check("t2_hold_dat2", epsilon_dat, 0);
        check("t2_hold_vld", epsilon_vld, 1);
        epsilon_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2_drain_vld%0d", i), epsilon_vld, 1);
            check($sformatf("t2_drain_dat%0d", i), epsilon_dat, exp_bits[i]);
            check($sformatf("t2_drain_first%0d", i), seq_first, (i == 0) ? 1 : 0);
            check($sformatf("t2_drain_last%0d", i), seq_last, (i == 3) ? 1 : 0);
            idle(1);
        end
        check("t2_empty", epsilon_vld, 0);
        check("t2_ovf_sticky", ovf, 1);

        // Full FIFO with simultaneous push and pop: nothing lost
        do_reset();
        epsilon_rdy = 1'b0;
        drive_raw(0); drive_raw(1);
        drive_raw(1); drive_raw(0);
        drive_raw(0); drive_raw(1);
        drive_raw(1); drive_raw(0);
        drive_raw(1);
        epsilon_rdy = 1'b1;
        drive_raw(0);
        epsilon_rdy = 1'b0;
        check("t3_ovf", ovf, 0);
        exp_bits[0] = 1; exp_bits[1] = 0; exp_bits[2] = 1; exp_bits[3] = 1;
        epsilon_rdy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_vld%0d", i), epsilon_vld, 1);
            check($sformatf("t3_dat%0d", i), epsilon_dat, exp_bits[i]);
            idle(1);
        end
        check("t3_empty", epsilon_vld, 0);

        // Sequence framing over 9 delivered bits
        do_reset();
        epsilon_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i % 2 == 0) begin drive_raw(0); drive_raw(1); end
            else            begin drive_raw(1); drive_raw(0); end
            check($sformatf("t4_vld%0d", i), epsilon_vld, 1);
            check($sformatf("t4_dat%0d", i), epsilon_dat, (i % 2 == 0) ? 0 : 1);
            check($sformatf("t4_first%0d", i), seq_first, (i % 4 == 0) ? 1 : 0);
            check($sformatf("t4_last%0d", i), seq_last, (i % 4 == 3) ? 1 : 0);
        end

        // en dropped between the two halves of a pair
        do_reset();
        epsilon_rdy = 1'b1;
        drive_raw(1);
        en = 1'b0;
        drive_raw(0);
        en = 1'b1;
        check("t5_discard", epsilon_vld, 0);
        idle(1);
        check("t5_discard2", epsilon_vld, 0);
        drive_raw(1); check("t5_half", epsilon_vld, 0);
        drive_raw(0);
        check("t5_vld", epsilon_vld, 1);
        check("t5_dat", epsilon_dat, 1);
        check("t5_first", seq_first, 1);

        // Repetition alarm after eight 1s; buffered bit flushed
        do_reset();
        epsilon_rdy = 1'b0;
        drive_raw(1); drive_raw(0);
        check("t6_buf_vld", epsilon_vld, 1);
        for (int i = 0; i < 7; i++) drive_raw(1);
        check("t6_rep_7", rep_fail, 0);
        check("t6_vld_7", epsilon_vld, 1);
        drive_raw(1);
        check("t6_rep_8", rep_fail, 1);
        check("t6_vld_8", epsilon_vld, 0);
        epsilon_rdy = 1'b1;
        drive_raw(0); drive_raw(1);
        drive_raw(1); drive_raw(0);
        check("t6_fail_vld", epsilon_vld, 0);
        check("t6_fail_sticky", rep_fail, 1);
        do_reset();
        epsilon_rdy = 1'b1;
        drive_raw(1); drive_raw(0);
        check("t6_resume_vld", epsilon_vld, 1);
        check("t6_resume_dat", epsilon_dat, 1);
        check("t6_resume_first", seq_first, 1);
        check("t6_resume_rep", rep_fail, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
